mcoi_diag_arbiter: RTL and testbench

MCOI_DIAG_ARBITER -- requirements
Module: mcoi_diag_arbiter

---
 rtl/mcoi_diag_pkg.sv | 21 ++
 rtl/mcoi_diag_arbiter_rr_pick.sv | 30 +++
 rtl/mcoi_diag_arbiter.sv | 140 ++++++++++++++
 tb/tb_mcoi_diag_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcoi_diag_pkg.sv
// Shared types and parameter defaults for the MCOI diagnostic register arbiter.
package mcoi_diag_pkg;

  localparam int N_REQ_DEF       = 4;
  localparam int AW_DEF          = 8;
  localparam int DW_DEF          = 16;
  localparam int TIMEOUT_CYC_DEF = 50000;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/mcoi_diag_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1 with wrap.
module rr_pick #(
  parameter int N_REQ = mcoi_diag_pkg::N_REQ_DEF,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] sel,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [2*N_REQ-1:0] rot2;

  // Rotating a doubled copy puts requester (ptr+1) mod N_REQ at bit 0.
  always_comb begin
    rot2 = {req, req} >> (int'(ptr) + 1);
    any  = 1'b0;
    idx  = '0;
    sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && rot2[i]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + 1 + i) % N_REQ);
      end
    end
    if (any) sel = N_REQ'(1) << idx;
  end

endmodule

// File: rtl/mcoi_diag_arbiter.sv
// Round-robin arbiter sharing one register-access engine between N_REQ diagnostic requesters,
// with a per-transaction timeout that answers all-ones and flags Err_o.
module mcoi_diag_arbiter
  import mcoi_diag_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  ckrs_t               ClkRs_ix,
  input  logic [N_REQ-1:0]    Req_ib,
  input  logic [N_REQ*AW-1:0] Addr_ib,
  input  logic [N_REQ-1:0]    Wr_ib,
  input  logic [N_REQ*DW-1:0] WData_ib,
  output logic [N_REQ-1:0]    Gnt_ob,
  output logic [N_REQ-1:0]    Done_ob,
  output logic [DW-1:0]       RData_ob,
  output logic                Err_o,
  output logic                Busy_o,
  output logic [7:0]          TimeoutCnt_ob,
  output logic                EngStart_o,
  output logic [AW-1:0]       EngAddr_ob,
  output logic                EngWr_o,
  output logic [DW-1:0]       EngWData_ob,
  input  logic                EngBusy_i,
  input  logic                EngDone_i,
  input  logic [DW-1:0]       EngRData_ib
);

  localparam int IW = $clog2(N_REQ);

  // Handshake: a requester holds Req_ib (with Addr/Wr/WData stable) until it sees its Done_ob
  // pulse; the engine takes a one-cycle EngStart_o when EngBusy_i is low and answers with a
  // one-cycle EngDone_i carrying EngRData_ib. Req_ib still high after Done_ob is a new request.

  logic          clk;
  logic          rst_n;
  state_e        state;
  logic [IW-1:0] ptr;
  logic [15:0]   cnt;

  logic [N_REQ-1:0] pick_sel;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [AW-1:0]    sel_addr;
  logic             sel_wr;
  logic [DW-1:0]    sel_wdata;

  assign clk   = ClkRs_ix.clk;
  assign rst_n = ClkRs_ix.reset;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .req (Req_ib),
    .ptr (ptr),
    .sel (pick_sel),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wr    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_sel[i]) begin
        sel_addr  = Addr_ib[i*AW +: AW];
        sel_wr    = Wr_ib[i];
        sel_wdata = WData_ib[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= IW'(N_REQ - 1);
      cnt           <= '0;
      Gnt_ob        <= '0;
      Done_ob       <= '0;
      RData_ob      <= '0;
      Err_o         <= 1'b0;
      Busy_o        <= 1'b0;
      TimeoutCnt_ob <= '0;
      EngStart_o    <= 1'b0;
      EngAddr_ob    <= '0;
      EngWr_o       <= 1'b0;
      EngWData_ob   <= '0;
    end else begin
      Done_ob    <= '0;
      EngStart_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            Gnt_ob      <= pick_sel;
            EngAddr_ob  <= sel_addr;
            EngWr_o     <= sel_wr;
            EngWData_ob <= sel_wdata;
            Busy_o      <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (!EngBusy_i) begin
            EngStart_o <= 1'b1;
            cnt        <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // A completion in the timeout cycle still counts as a real answer.
          if (EngDone_i) begin
            RData_ob <= EngRData_ib;
            Err_o    <= 1'b0;
            Done_ob  <= Gnt_ob;
            state    <= DONE;
          end else if (cnt == 16'(TIMEOUT_CYC - 1)) begin
            RData_ob <= '1;
            Err_o    <= 1'b1;
            Done_ob  <= Gnt_ob;
            if (TimeoutCnt_ob != 8'hFF) TimeoutCnt_ob <= TimeoutCnt_ob + 8'd1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          for (int i = 0; i < N_REQ; i++) begin
            if (Gnt_ob[i]) ptr <= IW'(i);
          end
          Gnt_ob <= '0;
          Busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcoi_diag_arbiter.sv
// Directed bench for mcoi_diag_arbiter: latency, round-robin order, timeout, busy engine, reset.
module tb_mcoi_diag_arbiter;
  import mcoi_diag_pkg::*;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ckrs_t       clkrs;
  logic [3:0]  req = '0;
  logic [31:0] addr = {8'h44, 8'h33, 8'h22, 8'h12};
  logic [3:0]  wr = '0;
  logic [63:0] wdata = {16'hD004, 16'hA5A5, 16'hB002, 16'hC001};
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [15:0] rdata;
  logic        err;
  logic        busy;
  logic [7:0]  tocnt;
  logic        eng_start;
  logic [7:0]  eng_addr;
  logic        eng_wr;
  logic [15:0] eng_wdata;
  logic        eng_busy = 1'b0;
  logic        eng_done = 1'b0;
  logic [15:0] eng_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  assign clkrs.clk   = clk;
  assign clkrs.reset = rst_n;

  always #5 clk = ~clk;

  mcoi_diag_arbiter #(.N_REQ(4), .AW(8), .DW(16), .TIMEOUT_CYC(TO)) dut (
    .ClkRs_ix      (clkrs),
    .Req_ib        (req),
    .Addr_ib       (addr),
    .Wr_ib         (wr),
    .WData_ib      (wdata),
    .Gnt_ob        (gnt),
    .Done_ob       (done),
    .RData_ob      (rdata),
    .Err_o         (err),
    .Busy_o        (busy),
    .TimeoutCnt_ob (tocnt),
    .EngStart_o    (eng_start),
    .EngAddr_ob    (eng_addr),
    .EngWr_o       (eng_wr),
    .EngWData_ob   (eng_wdata),
    .EngBusy_i     (eng_busy),
    .EngDone_i     (eng_done),
    .EngRData_ib   (eng_rdata)
  );

  // Driver: synchronous-release reset with all inputs quiet.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; eng_busy = 1'b0; eng_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Driver: advance negedges until gnt (0), eng_start (1) or done (2) shows up, bounded.
  task automatic wait_for(input int which, input int budget, output int cycles, output bit hit);
    hit = 1'b0;
    cycles = 0;
    while (!hit && cycles < budget) begin
      @(negedge clk);
      cycles++;
      case (which)
        0: hit = (gnt != 4'b0);
        1: hit = eng_start;
        2: hit = (done != 4'b0);
        default: hit = 1'b0;
      endcase
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({gnt, done, busy, err, eng_start} !== 11'b0) begin n_err++;
      $display("FAIL reset_ctrl got gnt=%b done=%b busy=%b err=%b start=%b want all 0", gnt, done, busy, err, eng_start); end
    n_vec++; if ({rdata, tocnt, eng_addr, eng_wr, eng_wdata} !== 49'b0) begin n_err++;
      $display("FAIL reset_data got rdata=%h tocnt=%0d eaddr=%h ewr=%b ewdata=%h want 0", rdata, tocnt, eng_addr, eng_wr, eng_wdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_single_read();
    int c; bit hit;
    wr = 4'b0000;
    req = 4'b0001;
    wait_for(0, 5, c, hit);
    n_vec++; if (!hit || c != 1 || gnt !== 4'b0001) begin n_err++;
      $display("FAIL rd_grant got gnt=%b after %0d cyc want 0001 after 1", gnt, c); end
    n_vec++; if (busy !== 1'b1 || eng_start !== 1'b0) begin n_err++;
      $display("FAIL rd_start_state got busy=%b start=%b want 1,0", busy, eng_start); end
    req = 4'b0000;
    wait_for(1, 5, c, hit);
    n_vec++; if (!hit || c != 1) begin n_err++;
      $display("FAIL rd_start_latency got %0d cyc after grant (hit=%b) want 1", c, hit); end
    n_vec++; if (eng_addr !== 8'h12 || eng_wr !== 1'b0 || eng_wdata !== 16'hC001) begin n_err++;
      $display("FAIL rd_eng_cmd got addr=%h wr=%b wdata=%h want 12,0,c001", eng_addr, eng_wr, eng_wdata); end
    repeat (9) @(negedge clk);
    n_vec++; if (eng_start !== 1'b0 || done !== 4'b0 || gnt !== 4'b0001) begin n_err++;
      $display("FAIL rd_wait got start=%b done=%b gnt=%b want 0,0000,0001", eng_start, done, gnt); end
    eng_done = 1'b1; eng_rdata = 16'hBEEF;
    @(negedge clk);
    eng_done = 1'b0; eng_rdata = 16'h0;
    n_vec++; if (done !== 4'b0001 || rdata !== 16'hBEEF || err !== 1'b0) begin n_err++;
      $display("FAIL rd_done got done=%b rdata=%h err=%b want 0001,beef,0", done, rdata, err); end
    @(negedge clk);
    n_vec++; if (done !== 4'b0 || gnt !== 4'b0 || busy !== 1'b0 || rdata !== 16'hBEEF) begin n_err++;
      $display("FAIL rd_after got done=%b gnt=%b busy=%b rdata=%h want 0,0,0,beef", done, gnt, busy, rdata); end
  endtask

  task automatic test_round_robin();
    int c; bit hit;
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      wait_for(0, 6, c, hit);
      n_vec++; if (!hit || gnt !== exp_g || !$onehot(gnt)) begin n_err++;
        $display("FAIL rr_grant_%0d got gnt=%b want %b", k, gnt, exp_g); end
      wait_for(1, 4, c, hit);
      n_vec++; if (!hit || eng_addr !== addr[(k % 4)*8 +: 8]) begin n_err++;
        $display("FAIL rr_addr_%0d got addr=%h (hit=%b) want %h", k, eng_addr, hit, addr[(k % 4)*8 +: 8]); end
      eng_done = 1'b1; eng_rdata = 16'h1000 + 16'(k);
      wait_for(2, 3, c, hit);
      eng_done = 1'b0;
      n_vec++; if (!hit || c != 1 || done !== exp_g || rdata !== 16'h1000 + 16'(k)) begin n_err++;
        $display("FAIL rr_done_%0d got done=%b rdata=%h after %0d want %b,%h after 1", k, done, rdata, c, exp_g, 16'h1000 + 16'(k)); end
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy_hold();
    int c; bit hit; int early;
    wr = 4'b0100;
    eng_busy = 1'b1;
    req = 4'b0100;
    wait_for(0, 5, c, hit);
    n_vec++; if (!hit || gnt !== 4'b0100) begin n_err++; $display("FAIL bh_grant got gnt=%b want 0100", gnt); end
    req = 4'b0000;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (eng_start !== 1'b0) early++;
    end
    n_vec++; if (early != 0) begin n_err++; $display("FAIL bh_early got %0d start cycles while busy want 0", early); end
    eng_busy = 1'b0;
    @(negedge clk);
    n_vec++; if (eng_start !== 1'b1 || eng_wr !== 1'b1 || eng_wdata !== 16'hA5A5 || eng_addr !== 8'h33) begin n_err++;
      $display("FAIL bh_start got start=%b wr=%b wdata=%h addr=%h want 1,1,a5a5,33", eng_start, eng_wr, eng_wdata, eng_addr); end
    early = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (eng_start !== 1'b0) early++;
    end
    n_vec++; if (early != 0) begin n_err++; $display("FAIL bh_once got %0d extra starts want 0", early); end
    eng_done = 1'b1; eng_rdata = 16'h0042;
    @(negedge clk);
    eng_done = 1'b0;
    n_vec++; if (done !== 4'b0100 || rdata !== 16'h0042 || eng_wdata !== 16'hA5A5) begin n_err++;
      $display("FAIL bh_done got done=%b rdata=%h ewdata=%h want 0100,0042,a5a5", done, rdata, eng_wdata); end
    wr = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int c; bit hit; int misses;
    do_reset();
    req = 4'b0010;
    wait_for(1, 5, c, hit);
    wait_for(2, 2 * TO, c, hit);
    n_vec++; if (!hit || c != TO) begin n_err++; $display("FAIL to_latency got %0d cyc (hit=%b) want %0d", c, hit, TO); end
    n_vec++; if (done !== 4'b0010 || rdata !== 16'hFFFF || err !== 1'b1 || tocnt !== 8'd1) begin n_err++;
      $display("FAIL to_first got done=%b rdata=%h err=%b tocnt=%0d want 0010,ffff,1,1", done, rdata, err, tocnt); end
    misses = 0;
    for (int k = 1; k < 300; k++) begin
      wait_for(1, 5, c, hit);
      if (!hit) misses++;
      wait_for(2, 2 * TO, c, hit);
      if (!hit) misses++;
    end
    req = 4'b0000;
    n_vec++; if (misses != 0) begin n_err++; $display("FAIL to_repeat got %0d missing events want 0", misses); end
    n_vec++; if (tocnt !== 8'd255 || err !== 1'b1) begin n_err++;
      $display("FAIL to_saturate got tocnt=%0d err=%b want 255,1", tocnt, err); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_done_vs_timeout();
    int c; bit hit; int early;
    do_reset();
    req = 4'b0001;
    wait_for(1, 5, c, hit);
    wait_for(2, 2 * TO, c, hit);
    n_vec++; if (!hit || tocnt !== 8'd1) begin n_err++; $display("FAIL tie_setup got tocnt=%0d (hit=%b) want 1", tocnt, hit); end
    wait_for(1, 5, c, hit);
    req = 4'b0000;
    early = 0;
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      if (done !== 4'b0) early++;
    end
    n_vec++; if (!hit || early != 0) begin n_err++; $display("FAIL tie_early got %0d early done (hit=%b) want 0", early, hit); end
    eng_done = 1'b1; eng_rdata = 16'h1234;
    @(negedge clk);
    eng_done = 1'b0;
    n_vec++; if (done !== 4'b0001 || err !== 1'b0 || rdata !== 16'h1234 || tocnt !== 8'd1) begin n_err++;
      $display("FAIL tie_done_wins got done=%b err=%b rdata=%h tocnt=%0d want 0001,0,1234,1", done, err, rdata, tocnt); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int c; bit hit; int stray;
    req = 4'b1000;
    wait_for(1, 6, c, hit);
    n_vec++; if (!hit || gnt !== 4'b1000) begin n_err++; $display("FAIL rw_setup got gnt=%b (hit=%b) want 1000", gnt, hit); end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({gnt, done, busy, err, eng_start, eng_addr, rdata, tocnt} !== 43'b0) begin n_err++;
      $display("FAIL rw_async got gnt=%b done=%b busy=%b err=%b start=%b addr=%h rdata=%h tocnt=%0d want 0",
               gnt, done, busy, err, eng_start, eng_addr, rdata, tocnt); end
    req = 4'b0000;
    stray = 0;
    repeat (2) begin @(negedge clk); if (done !== 4'b0) stray++; end
    rst_n = 1'b1;
    @(negedge clk);
    eng_done = 1'b1; eng_rdata = 16'h7777;
    @(negedge clk);
    eng_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 4'b0 || busy !== 1'b0 || gnt !== 4'b0 || rdata !== 16'h0) stray++;
    end
    n_vec++; if (stray != 0) begin n_err++; $display("FAIL rw_stray got %0d bad cycles want 0", stray); end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got no finish want finish before 5ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_busy_hold();
    test_timeout();
    test_done_vs_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
